// File: rtl/alu_serial.sv
// alu_serial: bit-serial NOR/XOR/ADD/SUB unit. A single full-adder slice is
// reused for WIDTH cycles, LSB first. The controller uses a start/busy/done
// handshake and may issue one operation at a time.
//
// Optional feature: define ALU_SERIAL_FLAGS_EN to add the zero and ovf
// ports and their flag logic. Without it those ports do not exist.
//
// Timing for a start accepted at edge k:
//   busy is high after edges k+1 .. k+WIDTH
//   done is high after edge k+WIDTH+1 only; result/cout/flags change there
//   the edge that ends the done cycle can already accept the next start
module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  // Reject unsupported widths while the design is being elaborated.
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("alu_serial: WIDTH must be in 2..64, got %0d", WIDTH);
  end

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  // Control and visible outputs (reset).
  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
`ifdef ALU_SERIAL_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cmsb_q, cmsb_d;   // carry into the MSB, for signed overflow
`endif

  // Datapath registers (not reset).
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  op_e              op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Single-bit slice signals.
  logic a_bit, b_bit, b_eff, sum_bit, carry_nxt, slice_bit, arith;

  // One-bit ALU slice working on the current LSBs of the operand shifters.
  always_comb begin
    a_bit     = a_sh_q[0];
    b_bit     = b_sh_q[0];
    arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    b_eff     = b_bit ^ (op_q == OP_SUB);
    sum_bit   = a_bit ^ b_eff ^ carry_q;
    carry_nxt = (a_bit & b_eff) | (carry_q & (a_bit ^ b_eff));
    unique case (op_q)
      OP_NOR:  slice_bit = ~(a_bit | b_bit);
      OP_XOR:  slice_bit = a_bit ^ b_bit;
      default: slice_bit = sum_bit;
    endcase
  end

  // Next-state, datapath and output computation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cmsb_d   = cmsb_q;
`endif

    // Handshake outputs trail the state by one cycle: the cycle right after
    // the accepting edge still shows busy=0, and done lines up with the
    // cycle after the last bit has been shifted in.
    busy_d = (state_q == S_RUN);
    done_d = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op_e'(op);
          carry_d = op[1] & op[0];   // SUB starts with the +1 of two's complement
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        acc_d  = {slice_bit, acc_q[WIDTH-1:1]};
        if (arith) carry_d = carry_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
`ifdef ALU_SERIAL_FLAGS_EN
          cmsb_d  = carry_q;
`endif
        end
      end
      S_DONE: begin
        // The accumulator is complete; publish it together with done.
        state_d  = S_IDLE;
        result_d = acc_q;
        cout_d   = arith & carry_q;
`ifdef ALU_SERIAL_FLAGS_EN
        zero_d   = (acc_q == '0);
        ovf_d    = arith & (cmsb_q ^ carry_q);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs, synchronously reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ALU_SERIAL_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Operand, accumulator and carry shifters.
  always_ff @(posedge clk) begin
    // NOTE: these registers carry no reset; they are always loaded on an
    // accepted start before being read, so a reset would only cost area.
    a_sh_q  <= a_sh_d;
    b_sh_q  <= b_sh_d;
    acc_q   <= acc_d;
    op_q    <= op_d;
    carry_q <= carry_d;
    cnt_q   <= cnt_d;
`ifdef ALU_SERIAL_FLAGS_EN
    cmsb_q  <= cmsb_d;
`endif
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
  assign zero   = zero_q;
  assign ovf    = ovf_q;
`endif

endmodule
